fp_peak_tracker: RTL and testbench

FP_PEAK_TRACKER -- requirements
Module: fp_peak_tracker
Interface
REQ-001 DW, 16, sample data width.
REQ-002 AW, 16, sample address width.
REQ-003 MAX_PEAKS, 49, reference peaks per sweep (>=2).
REQ-004 IDXW, 8, peak index width; 2**IDXW >= MAX_PEAKS.
REQ-005 sys_clk  in  1  single clock, rising edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 ad_start  in  1  sweep start; aborts to IDLE from any state.
REQ-008 data_wr_end  in  1  sweep buffer full pulse.
REQ-009 pi_flag  in  1  sample strobe.
REQ-010 pi_addr  in  AW  sample address.
REQ-011 pi_data  in  DW  sample amplitude.
REQ-012 amp_arm  in  DW  arm threshold (runtime).
REQ-013 amp_rise  in  DW  start-of-scan threshold (runtime).
REQ-014 peak_i  in  32  fitted peak, [15:0] integer, [31:16] fraction x1e-4.
REQ-015 peak_i_en  in  1  peak_i valid.
REQ-016 sample_i  in  32  fitted sensor peak, same format.
REQ-017 sample_i_en  in  1  sample_i valid.
REQ-018 peak_fit_en  out  1  one-cycle fit request per detected peak.
REQ-019 fit_str_addr  out  AW  fit window start = peak addr - 1.
REQ-020 min_str_addr  out  AW  first-peak window start.
REQ-021 min_end_addr  out  AW  valid-range end.
REQ-022 warning  out  8  sticky status bits.
REQ-023 bracket_vld  out  1  one-cycle result strobe.
REQ-024 left_idx  out  IDXW  lower bracketing peak index.
REQ-025 left_peak  out  32  table[left_idx], scaled.
REQ-026 right_peak  out  32  table[left_idx+1], scaled.
REQ-027 sample_peak  out  32  scaled sensor peak.
Function
REQ-028 Scaled value SHALL be int*10000+frac, 32-bit unsigned; table holds MAX_PEAKS entries written in order on peak_i_en; fit_cnt saturates at MAX_PEAKS, excess ignored.
REQ-029 3-sample window z2,z1,z0 SHALL shift on pi_flag; peak = pi_flag & z2<=z1 & z1>z0; valley = pi_flag & z2>=z1 & z1<z0.
REQ-030 States SHALL be IDLE, ARM, UP, DOWN, BUF_END, SEARCH, DONE; ad_start has priority over every other transition.
REQ-031 IDLE->ARM on pi_flag & pi_data<amp_arm; ARM->UP on pi_flag & pi_data>amp_rise.
REQ-032 UP: peak & det_cnt<MAX_PEAKS-1 -> DOWN, peak_fit_en=1, det_cnt+1; det_cnt==0 also loads min_str_addr=pi_addr-1.
REQ-033 UP: peak & det_cnt==MAX_PEAKS-1 -> BUF_END, peak_fit_en=1, min_end_addr=pi_addr-1.
REQ-034 DOWN->UP on valley; data_wr_end in UP/DOWN -> BUF_END, warning[0]=1, min_end_addr=pi_addr; data_wr_end beats same-cycle peak.
REQ-035 BUF_END: on sample_i_en latch sample_peak and go SEARCH; peak_i_en still accepted in BUF_END/SEARCH.
REQ-036 SEARCH: one index per cycle from 0; stop when table[i]<=sample_peak<=table[i+1]; latency <= MAX_PEAKS cycles.
REQ-037 sample_peak<table[0] -> left_idx=0, warning[1]=1; >table[fit_cnt-1] -> left_idx=fit_cnt-2, warning[1]=1; fit_cnt<2 -> warning[2]=1, left_idx=0.
REQ-038 Entering DONE SHALL pulse bracket_vld once; outputs hold until IDLE.
REQ-039 IDLE SHALL clear table, counters, warning, outputs to reset values.
Reset
REQ-040 Reset: state IDLE, table 0, min_str_addr/min_end_addr all-ones, others 0.
REQ-041 Mid-sweep reset or ad_start SHALL abandon the sweep without bracket_vld.
Configuration
REQ-042 With FP_FIT_TIMEOUT_EN defined, BUF_END waiting > 2**20 cycles for sample_i_en SHALL set warning[3], pulse bracket_vld, go DONE; without it, BUF_END waits indefinitely and warning[3]=0.
Verification
REQ-043 amp_arm=2450, amp_rise=2600, 3 triangular peaks at addr 100/200/300 -> peak_fit_en x3, fit_str_addr 99/199/299, min_str_addr 99.
REQ-044 peaks fitted 1527.2400/1528.0000/1528.8000, sample 1528.4000 -> left_idx=1, left_peak=15280000, right_peak=15288000.
REQ-045 sample 1520.0000 -> left_idx=0, warning[1]=1, bracket_vld once.
REQ-046 data_wr_end at addr 500 before MAX_PEAKS -> warning[0]=1, min_end_addr=500.
REQ-047 ad_start during SEARCH -> IDLE next cycle, no bracket_vld, table cleared.

---
 rtl/fp_peak_tracker.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_fp_peak_tracker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_peak_tracker.sv
// Sweep peak detector and reference-table bracketer: finds peaks in a sample sweep, collects the
// fitted peak values and brackets the fitted sensor peak. Optional macro: FP_FIT_TIMEOUT_EN.
module fp_peak_tracker #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int MAX_PEAKS = 49,
  parameter int IDXW      = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            ad_start,
  input  logic            data_wr_end,
  input  logic            pi_flag,
  input  logic [AW-1:0]   pi_addr,
  input  logic [DW-1:0]   pi_data,
  input  logic [DW-1:0]   amp_arm,
  input  logic [DW-1:0]   amp_rise,
  input  logic [31:0]     peak_i,
  input  logic            peak_i_en,
  input  logic [31:0]     sample_i,
  input  logic            sample_i_en,
  output logic            peak_fit_en,
  output logic [AW-1:0]   fit_str_addr,
  output logic [AW-1:0]   min_str_addr,
  output logic [AW-1:0]   min_end_addr,
  output logic [7:0]      warning,
  output logic            bracket_vld,
  output logic [IDXW-1:0] left_idx,
  output logic [31:0]     left_peak,
  output logic [31:0]     right_peak,
  output logic [31:0]     sample_peak
);

  localparam int TW = (MAX_PEAKS > 2) ? $clog2(MAX_PEAKS) : 1;
  localparam int CW = IDXW + 1;
  localparam logic [CW-1:0]   C_MAX     = CW'(MAX_PEAKS);
  localparam logic [CW-1:0]   C_MAXM1   = CW'(MAX_PEAKS - 1);
  localparam logic [CW-1:0]   C_ONE     = CW'(1);
  localparam logic [CW-1:0]   C_TWO     = CW'(2);
  localparam logic [IDXW-1:0] C_IDX_ONE = IDXW'(1);
  localparam logic [IDXW-1:0] C_IDX_TWO = IDXW'(2);
  localparam logic [TW-1:0]   C_TW_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_UP = 3'd2, S_DOWN = 3'd3,
    S_BUF_END = 3'd4, S_SEARCH = 3'd5, S_DONE = 3'd6
  } state_t;

  function automatic logic [31:0] scale_fp(input logic [31:0] raw);
    return ({16'd0, raw[15:0]} * 32'd10000) + {16'd0, raw[31:16]};
  endfunction

  state_t          r_state, w_state_nx;
  logic [DW-1:0]   r_z1, r_z2;
  logic [AW-1:0]   r_prev_addr;
  logic [31:0]     r_table [0:MAX_PEAKS-1];
  logic [CW-1:0]   r_fit_cnt, r_det_cnt;
  logic [IDXW-1:0] r_idx;
  logic            r_peak_fit_en, r_bracket_vld;
  logic [AW-1:0]   r_fit_str_addr, r_min_str_addr, r_min_end_addr;
  logic [7:0]      r_warning;
  logic [IDXW-1:0] r_left_idx;
  logic [31:0]     r_left_peak, r_right_peak, r_sample_peak;

  logic            w_peak, w_valley, w_timeout_hit;
  logic            w_fit_req, w_last_peak, w_wr_end, w_latch_smp, w_srch_done, w_timeout;
  logic            w_stop, w_warn_rng, w_warn_few;
  logic [IDXW-1:0] w_left, w_idx_nx, w_last_left;
  logic [TW-1:0]   w_right;
  logic [31:0]     w_tbl_lo, w_tbl_hi;

  // The current sample is the newest window tap, so a detected peak sits at the previous address.
  assign w_peak   = pi_flag && (r_z2 <= r_z1) && (r_z1 > pi_data);
  assign w_valley = pi_flag && (r_z2 >= r_z1) && (r_z1 < pi_data);

  assign w_idx_nx    = r_idx + C_IDX_ONE;
  assign w_last_left = r_fit_cnt[IDXW-1:0] - C_IDX_TWO;
  assign w_tbl_lo    = r_table[r_idx[TW-1:0]];
  assign w_tbl_hi    = r_table[w_idx_nx[TW-1:0]];
  assign w_right     = w_left[TW-1:0] + C_TW_ONE;

`ifdef FP_FIT_TIMEOUT_EN
  logic [20:0] r_to_cnt;

  // Counts cycles spent waiting in BUF_END for the sensor fit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_to_cnt <= 21'd0;
    end else if ((r_state == S_BUF_END) && !ad_start) begin
      r_to_cnt <= r_to_cnt + 21'd1;
    end else begin
      r_to_cnt <= 21'd0;
    end
  end

  assign w_timeout_hit = (r_to_cnt == 21'h100000);
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Bracket search: one table index per cycle, out-of-range samples clamp to the end pairs.
  always_comb begin
    w_stop     = 1'b0;
    w_warn_rng = 1'b0;
    w_warn_few = 1'b0;
    w_left     = r_idx;
    if (r_fit_cnt < C_TWO) begin
      w_stop     = 1'b1;
      w_warn_few = 1'b1;
      w_left     = {IDXW{1'b0}};
    end else if ((w_tbl_lo <= r_sample_peak) && (r_sample_peak <= w_tbl_hi)) begin
      w_stop = 1'b1;
    end else if (r_sample_peak < r_table[0]) begin
      w_stop     = 1'b1;
      w_warn_rng = 1'b1;
      w_left     = {IDXW{1'b0}};
    end else if ({1'b0, r_idx} >= (r_fit_cnt - C_TWO)) begin
      w_stop     = 1'b1;
      w_warn_rng = 1'b1;
      w_left     = w_last_left;
    end else begin
      w_stop = 1'b0;
    end
  end

  // Next-state logic; ad_start overrides every other transition.
  always_comb begin
    w_state_nx  = r_state;
    w_fit_req   = 1'b0;
    w_last_peak = 1'b0;
    w_wr_end    = 1'b0;
    w_latch_smp = 1'b0;
    w_srch_done = 1'b0;
    w_timeout   = 1'b0;
    if (ad_start) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pi_flag && (pi_data < amp_arm)) w_state_nx = S_ARM;
          else                                w_state_nx = S_IDLE;
        end
        S_ARM: begin
          if (pi_flag && (pi_data > amp_rise)) w_state_nx = S_UP;
          else                                 w_state_nx = S_ARM;
        end
        S_UP: begin
          if (data_wr_end) begin
            w_state_nx = S_BUF_END;
            w_wr_end   = 1'b1;
          end else if (w_peak) begin
            w_fit_req = 1'b1;
            if (r_det_cnt < C_MAXM1) begin
              w_state_nx = S_DOWN;
            end else begin
              w_state_nx  = S_BUF_END;
              w_last_peak = 1'b1;
            end
          end else begin
            w_state_nx = S_UP;
          end
        end
        S_DOWN: begin
          if (data_wr_end) begin
            w_state_nx = S_BUF_END;
            w_wr_end   = 1'b1;
          end else if (w_valley) begin
            w_state_nx = S_UP;
          end else begin
            w_state_nx = S_DOWN;
          end
        end
        S_BUF_END: begin
          if (sample_i_en) begin
            w_state_nx  = S_SEARCH;
            w_latch_smp = 1'b1;
          end else if (w_timeout_hit) begin
            w_state_nx = S_DONE;
            w_timeout  = 1'b1;
          end else begin
            w_state_nx = S_BUF_END;
          end
        end
        S_SEARCH: begin
          if (w_stop) begin
            w_state_nx  = S_DONE;
            w_srch_done = 1'b1;
          end else begin
            w_state_nx = S_SEARCH;
          end
        end
        S_DONE:  w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  // Sample window and the address of its newest tap; runs in every state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_z1        <= {DW{1'b0}};
      r_z2        <= {DW{1'b0}};
      r_prev_addr <= {AW{1'b0}};
    end else if (pi_flag) begin
      r_z2        <= r_z1;
      r_z1        <= pi_data;
      r_prev_addr <= pi_addr;
    end else begin
      r_z1 <= r_z1;
    end
  end

  // Search index restarts from zero every time SEARCH is entered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                r_idx <= {IDXW{1'b0}};
    else if (r_state == S_SEARCH)  r_idx <= w_idx_nx;
    else                           r_idx <= {IDXW{1'b0}};
  end

  // Peak table, counters, status and result registers; an abort clears them on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < MAX_PEAKS; i++) r_table[i] <= 32'd0;
      r_fit_cnt      <= {CW{1'b0}};
      r_det_cnt      <= {CW{1'b0}};
      r_peak_fit_en  <= 1'b0;
      r_bracket_vld  <= 1'b0;
      r_fit_str_addr <= {AW{1'b0}};
      r_min_str_addr <= {AW{1'b1}};
      r_min_end_addr <= {AW{1'b1}};
      r_warning      <= 8'd0;
      r_left_idx     <= {IDXW{1'b0}};
      r_left_peak    <= 32'd0;
      r_right_peak   <= 32'd0;
      r_sample_peak  <= 32'd0;
    end else if (ad_start || (r_state == S_IDLE)) begin
      for (int i = 0; i < MAX_PEAKS; i++) r_table[i] <= 32'd0;
      r_fit_cnt      <= {CW{1'b0}};
      r_det_cnt      <= {CW{1'b0}};
      r_peak_fit_en  <= 1'b0;
      r_bracket_vld  <= 1'b0;
      r_fit_str_addr <= {AW{1'b0}};
      r_min_str_addr <= {AW{1'b1}};
      r_min_end_addr <= {AW{1'b1}};
      r_warning      <= 8'd0;
      r_left_idx     <= {IDXW{1'b0}};
      r_left_peak    <= 32'd0;
      r_right_peak   <= 32'd0;
      r_sample_peak  <= 32'd0;
    end else begin
      r_peak_fit_en <= w_fit_req;
      r_bracket_vld <= w_srch_done || w_timeout;
      if (peak_i_en && (r_state != S_DONE) && (r_fit_cnt < C_MAX)) begin
        r_table[r_fit_cnt[TW-1:0]] <= scale_fp(peak_i);
        r_fit_cnt <= r_fit_cnt + C_ONE;
      end
      if (w_fit_req) begin
        r_fit_str_addr <= r_prev_addr - {{(AW-1){1'b0}}, 1'b1};
        r_det_cnt      <= r_det_cnt + C_ONE;
        if (r_det_cnt == {CW{1'b0}}) r_min_str_addr <= r_prev_addr - {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_last_peak) r_min_end_addr <= r_prev_addr - {{(AW-1){1'b0}}, 1'b1};
      if (w_wr_end) begin
        r_min_end_addr <= pi_addr;
        r_warning[0]   <= 1'b1;
      end
      if (w_latch_smp) r_sample_peak <= scale_fp(sample_i);
      if (w_srch_done) begin
        r_left_idx   <= w_left;
        r_left_peak  <= r_table[w_left[TW-1:0]];
        r_right_peak <= r_table[w_right];
        if (w_warn_rng) r_warning[1] <= 1'b1;
        if (w_warn_few) r_warning[2] <= 1'b1;
      end
      if (w_timeout) r_warning[3] <= 1'b1;
    end
  end

  assign peak_fit_en  = r_peak_fit_en;
  assign fit_str_addr = r_fit_str_addr;
  assign min_str_addr = r_min_str_addr;
  assign min_end_addr = r_min_end_addr;
  assign warning      = r_warning;
  assign bracket_vld  = r_bracket_vld;
  assign left_idx     = r_left_idx;
  assign left_peak    = r_left_peak;
  assign right_peak   = r_right_peak;
  assign sample_peak  = r_sample_peak;

endmodule

// File: tb/tb_fp_peak_tracker.sv
// Directed bench for fp_peak_tracker: triangular sweeps, bracketing, range warnings,
// abort during SEARCH and the full-table end of sweep.
module tb_fp_peak_tracker;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n, ad_start, data_wr_end, pi_flag, peak_i_en, sample_i_en;
  logic [15:0] pi_addr, pi_data, amp_arm, amp_rise;
  logic [31:0] peak_i, sample_i;
  logic        peak_fit_en, bracket_vld;
  logic [15:0] fit_str_addr, min_str_addr, min_end_addr;
  logic [7:0]  warning, left_idx;
  logic [31:0] left_peak, right_peak, sample_peak;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_fit = 0;
  int          n_brk = 0;
  logic [15:0] fit_q[$];

  always #5 sys_clk = ~sys_clk;

  fp_peak_tracker dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_start(ad_start), .data_wr_end(data_wr_end),
    .pi_flag(pi_flag), .pi_addr(pi_addr), .pi_data(pi_data), .amp_arm(amp_arm), .amp_rise(amp_rise),
    .peak_i(peak_i), .peak_i_en(peak_i_en), .sample_i(sample_i), .sample_i_en(sample_i_en),
    .peak_fit_en(peak_fit_en), .fit_str_addr(fit_str_addr), .min_str_addr(min_str_addr),
    .min_end_addr(min_end_addr), .warning(warning), .bracket_vld(bracket_vld), .left_idx(left_idx),
    .left_peak(left_peak), .right_peak(right_peak), .sample_peak(sample_peak)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (peak_fit_en === 1'b1) begin
      n_fit++;
      fit_q.push_back(fit_str_addr);
    end
    if (bracket_vld === 1'b1) n_brk++;
  endtask

  task automatic sample(input int a, input int d);
    pi_flag = 1'b1;
    pi_addr = a[15:0];
    pi_data = d[15:0];
    tick();
    pi_flag = 1'b0;
  endtask

  function automatic int tri_val(input int a);
    int best = 1000;
    for (int p = 100; p <= 300; p += 100) begin
      int d = (a > p) ? a - p : p - a;
      if (d < best) best = d;
    end
    return (best < 40) ? 2800 - 10 * best : 2400;
  endfunction

  task automatic run_triangles();
    for (int a = 0; a < 350; a++) sample(a, tri_val(a));
  endtask

  task automatic fit(input int ip, input int fr);
    peak_i    = {fr[15:0], ip[15:0]};
    peak_i_en = 1'b1;
    tick();
    peak_i_en = 1'b0;
  endtask

  task automatic fit_three();
    fit(1527, 2400);
    fit(1528, 0);
    fit(1528, 8000);
  endtask

  task automatic wr_end(input int a);
    data_wr_end = 1'b1;
    pi_addr     = a[15:0];
    tick();
    data_wr_end = 1'b0;
  endtask

  task automatic give_sample(input int ip, input int fr);
    sample_i    = {fr[15:0], ip[15:0]};
    sample_i_en = 1'b1;
    tick();
    sample_i_en = 1'b0;
  endtask

  task automatic abort();
    ad_start = 1'b1;
    tick();
    ad_start = 1'b0;
    n_fit = 0;
    n_brk = 0;
    fit_q.delete();
  endtask

  initial begin
    sys_rst_n = 1'b0; ad_start = 1'b0; data_wr_end = 1'b0; pi_flag = 1'b0;
    peak_i_en = 1'b0; sample_i_en = 1'b0; pi_addr = 16'd0; pi_data = 16'd0;
    amp_arm = 16'd2450; amp_rise = 16'd2600; peak_i = 32'd0; sample_i = 32'd0;
    repeat (3) tick();
    check("rst_min_str", {16'd0, min_str_addr}, 32'h0000FFFF);
    check("rst_min_end", {16'd0, min_end_addr}, 32'h0000FFFF);
    check("rst_warning", {24'd0, warning}, 32'd0);
    check("rst_bracket", {31'd0, bracket_vld}, 32'd0);
    check("rst_fit_en", {31'd0, peak_fit_en}, 32'd0);
    check("rst_left_peak", left_peak, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // Three triangular peaks, early buffer end, sample inside the table.
    n_fit = 0; n_brk = 0; fit_q.delete();
    run_triangles();
    check("a_fit_count", n_fit, 32'd3);
    check("a_fit_str0", {16'd0, fit_q[0]}, 32'd99);
    check("a_fit_str1", {16'd0, fit_q[1]}, 32'd199);
    check("a_fit_str2", {16'd0, fit_q[2]}, 32'd299);
    check("a_min_str", {16'd0, min_str_addr}, 32'd99);
    fit_three();
    wr_end(500);
    check("a_warn_wr_end", {24'd0, warning}, 32'h01);
    check("a_min_end", {16'd0, min_end_addr}, 32'd500);
    give_sample(1528, 4000);
    repeat (60) tick();
    check("a_bracket_cnt", n_brk, 32'd1);
    check("a_left_idx", {24'd0, left_idx}, 32'd1);
    check("a_left_peak", left_peak, 32'd15280000);
    check("a_right_peak", right_peak, 32'd15288000);
    check("a_sample_peak", sample_peak, 32'd15284000);
    check("a_warning", {24'd0, warning}, 32'h01);

    // Abort clears results; sample below the table.
    abort();
    check("b_clr_warning", {24'd0, warning}, 32'd0);
    check("b_clr_min_end", {16'd0, min_end_addr}, 32'h0000FFFF);
    check("b_clr_sample", sample_peak, 32'd0);
    run_triangles();
    fit_three();
    wr_end(400);
    give_sample(1520, 0);
    repeat (60) tick();
    check("b_bracket_cnt", n_brk, 32'd1);
    check("b_left_idx", {24'd0, left_idx}, 32'd0);
    check("b_warning", {24'd0, warning}, 32'h03);
    check("b_left_peak", left_peak, 32'd15272400);
    check("b_right_peak", right_peak, 32'd15280000);

    // Sample above the table clamps to the last pair.
    abort();
    run_triangles();
    fit_three();
    wr_end(400);
    give_sample(1530, 0);
    repeat (60) tick();
    check("c_bracket_cnt", n_brk, 32'd1);
    check("c_left_idx", {24'd0, left_idx}, 32'd1);
    check("c_warning", {24'd0, warning}, 32'h03);
    check("c_right_peak", right_peak, 32'd15288000);

    // ad_start while SEARCH is still scanning; the table must come back empty.
    abort();
    run_triangles();
    fit_three();
    wr_end(450);
    give_sample(1528, 4000);
    abort();
    repeat (10) tick();
    check("d_no_bracket", n_brk, 32'd0);
    check("d_sample_clr", sample_peak, 32'd0);
    check("d_warning_clr", {24'd0, warning}, 32'd0);
    run_triangles();
    wr_end(500);
    give_sample(1528, 4000);
    repeat (10) tick();
    check("d_bracket_cnt", n_brk, 32'd1);
    check("d_warning", {24'd0, warning}, 32'h05);
    check("d_left_peak", left_peak, 32'd0);
    check("d_right_peak", right_peak, 32'd0);

    // MAX_PEAKS peaks end the sweep by themselves.
    abort();
    sample(0, 2400);
    sample(1, 2700);
    for (int a = 2; a < 120; a++) sample(a, (a % 2 == 0) ? 2800 : 2700);
    check("e_fit_count", n_fit, 32'd49);
    check("e_last_fit_str", {16'd0, fit_q[48]}, 32'd97);
    check("e_min_str", {16'd0, min_str_addr}, 32'd1);
    check("e_min_end", {16'd0, min_end_addr}, 32'd97);
    check("e_warning", {24'd0, warning}, 32'd0);
    give_sample(1528, 0);
    repeat (10) tick();
    check("e_bracket_cnt", n_brk, 32'd1);
    check("e_warn_few", {24'd0, warning}, 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
